// File: rtl/reg_file_nport_pkg.sv
// reg_file_nport_pkg: default geometry and address-width helper for the register file.
package reg_file_nport_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NREAD = 2;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/reg_file_nport_read_mux.sv
// read_mux: DEPTH:1 word select; out-of-range selects return zero.
module read_mux
    import reg_file_nport_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = clog2(DEPTH)
) (
    input  logic [DEPTH*WIDTH-1:0] data_i,
    input  logic [AW-1:0]          sel_i,
    output logic [WIDTH-1:0]       data_o
);
    always_comb begin
        data_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (sel_i == AW'(i)) data_o = data_i[i*WIDTH +: WIDTH];
    end
endmodule

// File: rtl/reg_file_nport.sv
// reg_file_nport: DEPTH x WIDTH register file, one write port, NREAD read ports,
// optional hardwired-zero register 0, write bypass and registered read data.
module reg_file_nport
    import reg_file_nport_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NREAD    = DEF_NREAD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REG_OUT  = 0,
    localparam int AW = clog2(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   WrEn,
    input  logic [AW-1:0]          WrAddr,
    input  logic [WIDTH-1:0]       WrData,
    input  logic [NREAD*AW-1:0]    RdAddr,
    output logic [NREAD*WIDTH-1:0] RdData
);
    logic [WIDTH-1:0]       regs_q [DEPTH];
    logic [DEPTH*WIDTH-1:0] flat;
    logic [NREAD*WIDTH-1:0] rd_d;
    logic                   wr_ok;

    // a write that will actually land; also the only condition under which bypass applies
    assign wr_ok = Reset && WrEn && ({1'b0, WrAddr} < (AW+1)'(DEPTH))
                   && !(ZERO_REG != 0 && WrAddr == '0);

    always_ff @(posedge Clk) begin
        if (!Reset) for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        else if (wr_ok) regs_q[WrAddr] <= WrData;
    end

    genvar i, k;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_flat
            assign flat[i*WIDTH +: WIDTH] = (ZERO_REG != 0 && i == 0) ? '0 : regs_q[i];
        end
        for (k = 0; k < NREAD; k++) begin : g_rd
            logic [AW-1:0]    ra;
            logic [WIDTH-1:0] mux_o;
            assign ra = RdAddr[k*AW +: AW];
            read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mux (
                .data_i(flat),
                .sel_i (ra),
                .data_o(mux_o)
            );
            assign rd_d[k*WIDTH +: WIDTH] = (BYPASS != 0 && wr_ok && ra == WrAddr) ? WrData : mux_o;
        end
        if (REG_OUT != 0) begin : g_reg
            logic [NREAD*WIDTH-1:0] rd_q;
            always_ff @(posedge Clk) begin
                if (!Reset) rd_q <= '0;
                else rd_q <= rd_d;
            end
            assign RdData = rd_q;
        end else begin : g_comb
            assign RdData = rd_d;
        end
    endgenerate
endmodule

// File: tb/tb_reg_file_nport.sv
// tb_reg_file_nport: three configurations checked against an array model, directed
// vectors and sequences, then randomized traffic.
module tb_reg_file_nport;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset;
    logic        we0, we1, we2;
    logic [4:0]  wa0, wa1, wa2;
    logic [31:0] wd0, wd1;
    logic [15:0] wd2;
    logic [9:0]  ra0, ra1;
    logic [19:0] ra2;
    logic [63:0] rd0, rd1, rd2;
    int errs = 0, checks = 0;

    logic [31:0] mem [3][32];
    int dep [3] = '{32, 20, 32};
    bit zr  [3] = '{1, 0, 1};
    bit bp  [3] = '{1, 0, 1};

    reg_file_nport u0 (.Clk(Clk), .Reset(Reset), .WrEn(we0), .WrAddr(wa0), .WrData(wd0),
                       .RdAddr(ra0), .RdData(rd0));
    reg_file_nport #(.DEPTH(20), .ZERO_REG(0), .BYPASS(0)) u1 (
        .Clk(Clk), .Reset(Reset), .WrEn(we1), .WrAddr(wa1), .WrData(wd1),
        .RdAddr(ra1), .RdData(rd1));
    reg_file_nport #(.WIDTH(16), .NREAD(4), .REG_OUT(1)) u2 (
        .Clk(Clk), .Reset(Reset), .WrEn(we2), .WrAddr(wa2), .WrData(wd2),
        .RdAddr(ra2), .RdData(rd2));

    function automatic bit wr_ok(int u, logic rst, logic we, logic [4:0] wa);
        return rst && we && int'(wa) < dep[u] && !(zr[u] && wa == 5'd0);
    endfunction

    function automatic logic [31:0] model_rd(int u, logic rst, logic we, logic [4:0] wa,
                                             logic [31:0] wd, logic [4:0] a);
        if (int'(a) >= dep[u] || (zr[u] && a == 5'd0)) return '0;
        if (bp[u] && wr_ok(u, rst, we, wa) && a == wa) return wd;
        return mem[u][a];
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // one clock: combinational ports checked mid-cycle, registered ports after the edge
    task automatic tick();
        logic [31:0] e2 [4];
        @(negedge Clk);
        for (int k = 0; k < 2; k++) chk("u0 model", rd0[k*32 +: 32], model_rd(0, Reset, we0, wa0, wd0, ra0[k*5 +: 5]));
        for (int k = 0; k < 2; k++) chk("u1 model", rd1[k*32 +: 32], model_rd(1, Reset, we1, wa1, wd1, ra1[k*5 +: 5]));
        for (int k = 0; k < 4; k++) e2[k] = Reset ? model_rd(2, Reset, we2, wa2, {16'h0, wd2}, ra2[k*5 +: 5]) : '0;
        @(posedge Clk);
        if (!Reset) begin
            for (int u = 0; u < 3; u++) for (int a = 0; a < 32; a++) mem[u][a] = '0;
        end else begin
            if (wr_ok(0, Reset, we0, wa0)) mem[0][wa0] = wd0;
            if (wr_ok(1, Reset, we1, wa1)) mem[1][wa1] = wd1;
            if (wr_ok(2, Reset, we2, wa2)) mem[2][wa2] = {16'h0, wd2};
        end
        #1;
        for (int k = 0; k < 4; k++) chk("u2 model", {16'h0, rd2[k*16 +: 16]}, e2[k]);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a0, a1;
        logic [31:0] e0, e1;
    } vec_t;
    vec_t tv [7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int u = 0; u < 3; u++) for (int a = 0; a < 32; a++) mem[u][a] = '0;
        tv[0] = '{1'b1, 5'd7,  32'h1234_5678, 5'd7,  5'd7,  32'h1234_5678, 32'h1234_5678};
        tv[1] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd0,  32'h1234_5678, 32'h0};
        tv[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0};
        tv[3] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0};
        tv[4] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd5,  32'hCAFE_F00D, 32'h0};
        tv[5] = '{1'b1, 5'd5,  32'h0000_0055, 5'd31, 5'd5,  32'hCAFE_F00D, 32'h0000_0055};
        tv[6] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd31, 32'h0000_0055, 32'hCAFE_F00D};

        Reset = 1'b0;
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; ra0 = {5'd5, 5'd5};
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEAD_BEEF; ra1 = {5'd5, 5'd5};
        we2 = 1'b1; wa2 = 5'd5; wd2 = 16'hBEEF;      ra2 = {4{5'd5}};
        repeat (2) @(posedge Clk);
        #1;
        tick();
        Reset = 1'b1; we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
        #3;
        chk("reset u0 p0", rd0[31:0], 32'h0);
        chk("reset u0 p1", rd0[63:32], 32'h0);
        chk("reset u1 p0", rd1[31:0], 32'h0);
        tick();
        chk("reset u2 p0", {16'h0, rd2[15:0]}, 32'h0);

        for (int i = 0; i < 7; i++) begin
            we0 = tv[i].we; wa0 = tv[i].wa; wd0 = tv[i].wd; ra0 = {tv[i].a1, tv[i].a0};
            #3;
            chk("vector p0", rd0[31:0], tv[i].e0);
            chk("vector p1", rd0[63:32], tv[i].e1);
            tick();
        end

        for (int i = 1; i < 32; i++) begin
            we0 = 1'b1; wa0 = 5'(i); wd0 = 32'(i) * 32'h0101_0101;
            tick();
        end
        we0 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra0 = {5'(31 - i), 5'(i)};
            #3;
            chk("sweep p0", rd0[31:0], 32'(i) * 32'h0101_0101);
            chk("sweep p1", rd0[63:32], 32'(31 - i) * 32'h0101_0101);
            tick();
        end

        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; ra0 = {5'd0, 5'd0};
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF; ra1 = {5'd0, 5'd0};
        #3;
        chk("u0 zero same", rd0[31:0], 32'h0);
        chk("u1 zero old", rd1[31:0], 32'h0);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #3;
        chk("u0 zero after", rd0[63:32], 32'h0);
        chk("u1 reg0 after", rd1[31:0], 32'hFFFF_FFFF);
        tick();

        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h1234_5678; ra1 = {5'd7, 5'd7};
        #3;
        chk("u1 nobypass old", rd1[31:0], 32'h0);
        tick();
        we1 = 1'b0;
        #3;
        chk("u1 nobypass new", rd1[63:32], 32'h1234_5678);
        tick();
        we1 = 1'b1; wa1 = 5'd25; wd1 = 32'hA5A5_A5A5; ra1 = {5'd19, 5'd25};
        #3;
        chk("u1 read 25 same", rd1[31:0], 32'h0);
        tick();
        wa1 = 5'd19; wd1 = 32'h0000_0013;
        tick();
        we1 = 1'b0;
        #3;
        chk("u1 read 25", rd1[31:0], 32'h0);
        chk("u1 read 19", rd1[63:32], 32'h0000_0013);
        tick();

        for (int i = 1; i < 4; i++) begin
            we2 = 1'b1; wa2 = 5'(i); wd2 = 16'(i);
            tick();
        end
        we2 = 1'b0; ra2 = {5'd1, 5'd3, 5'd2, 5'd1};
        tick();
        chk("u2 port0", {16'h0, rd2[15:0]},  32'h1);
        chk("u2 port1", {16'h0, rd2[31:16]}, 32'h2);
        chk("u2 port2", {16'h0, rd2[47:32]}, 32'h3);
        chk("u2 port3", {16'h0, rd2[63:48]}, 32'h1);
        we2 = 1'b1; wa2 = 5'd7; wd2 = 16'h5678; ra2 = {4{5'd7}};
        #3;
        chk("u2 latency", {16'h0, rd2[15:0]}, 32'h1);
        tick();
        for (int k = 0; k < 4; k++) chk("u2 bypass", {16'h0, rd2[k*16 +: 16]}, 32'h5678);

        repeat (400) begin
            Reset = ($urandom_range(0, 31) != 0);
            we0 = 1'($urandom); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom;
            ra0 = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            we1 = 1'($urandom); wa1 = 5'($urandom); wd1 = $urandom; ra1 = 10'($urandom);
            we2 = 1'($urandom); wa2 = 5'($urandom_range(0, 7)); wd2 = 16'($urandom);
            for (int k = 0; k < 4; k++) ra2[k*5 +: 5] = 5'($urandom_range(0, 7));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
